pulse_gen_ctrl: RTL and testbench
=================================

# pulse_gen_ctrl

Front-panel controller for `pulse_generator`. It synchronises and debounces the three active-low `key` buttons and turns debounced presses into the generator's control inputs: a registered `mode_sel` that cycles on each press, and single-cycle `write_add_subtract` / `read_add_subtract` step strobes with hold-to-repeat. It sits between the board pins and `pulse_generator`, in the same 50 MHz `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz).
- `REPEAT_DELAY`, 25_000_000: cycles from the first strobe of a held step key to its first auto-repeat strobe.
- `REPEAT_PERIOD`, 5_000_000: cycles between successive auto-repeat strobes.
- `NUM_MODES`, 8: number of valid modes, 1..8; `mode_sel` runs 0..NUM_MODES-1.
- `MODE_RESET`, 3'd0: `mode_sel` value after reset; must be < NUM_MODES.
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  synchronous, active-low reset.
- `key`  in  3  raw, asynchronous, active-low buttons: [0] mode, [1] write step, [2] read step.
- `mode_sel`  out  3  registered mode select to `pulse_generator`.
- `write_add_subtract`  out  1  one-cycle strobe, write-side step request.
- `read_add_subtract`  out  1  one-cycle strobe, read-side step request.
- `key_held`  out  3  debounced pressed level, 1 = pressed.

## Operation
- Reset (`reset_n`=0 at a rising edge):
  - `mode_sel`=MODE_RESET; both strobes 0; `key_held`=3'b000.
  - Synchronisers load 1 (released); debounce and repeat counters clear.
  - Reset applies mid-debounce and mid-repeat alike; a key held through reset is seen as a new press once debounced after release of reset.
- Per key, one `key_debounce` instance:
  - 2-FF synchroniser.
  - Counter runs while the synced level differs from the stable level and clears on any cycle they match.
  - The stable level updates when the counter reaches DEBOUNCE_CYCLES.
  - Press event = stable 1→0; release event = stable 0→1.
- Mode key (no auto-repeat):
  - On a press event, `mode_sel` increments; NUM_MODES-1 wraps to 0.
  - Holding the key produces no further change.
- Step keys [1] and [2], independent FSM each. States IDLE, DELAY, REPEAT:
  - IDLE → DELAY on a press event: strobe once, load the repeat counter with REPEAT_DELAY.
  - DELAY → REPEAT when the counter expires: strobe, reload with REPEAT_PERIOD.
  - REPEAT → REPEAT on each expiry: strobe, reload.
  - DELAY/REPEAT → IDLE on a release event. No strobe is issued in the release cycle, even if the counter expires in that cycle.
- Simultaneous events:
  - Keys are fully independent. Both strobes may assert in the same cycle, together with a `mode_sel` change.
- Counter widths: `$clog2` of the largest of the parameters, so there is no overflow at the defaults.

## Timing
- Raw key edge captured at edge 1 → sync output at edge 2 → stable level updates at edge 2+DEBOUNCE_CYCLES.
- Press-to-output latency: strobe/`mode_sel` update/`key_held` all registered at edge 3+DEBOUNCE_CYCLES, measured from the first edge sampling the new raw level.
- Strobe width: exactly 1 cycle.
- Spacing for a held step key:
  - First to second strobe: REPEAT_DELAY cycles.
  - Thereafter: REPEAT_PERIOD cycles.
- A raw glitch shorter than DEBOUNCE_CYCLES produces no event and no `key_held` change.
- All outputs come straight from flops; there is no combinational path from `key`.

## Structure
- Package `pulse_gen_pkg`:
  - Key index constants: KEY_MODE=0, KEY_WR=1, KEY_RD=2.
  - Repeat-FSM state enum: IDLE, DELAY, REPEAT.
  - Mode width constant: 3.
- Sub-module `key_debounce`:
  - Parameter DEBOUNCE_CYCLES.
  - Ports: `clk`, `reset_n`, `key_n`, `held`, `press`, `release`.
  - Instantiated 3×.
- The top level holds the mode counter and two repeat FSMs, from one shared FSM code body generated for keys 1 and 2.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, NUM_MODES=5, MODE_RESET=0.
- Reset: hold `reset_n`=0 with `key`=3'b000 → `mode_sel`=0, strobes 0, `key_held`=0. Release reset → `key_held`=3'b111 and both strobes pulse at cycle 7.
- Mode wrap: five clean presses of `key[0]` → `mode_sel` reads 1,2,3,4,0. Each update occurs 7 cycles after the press edge; holding 100 cycles causes no extra change.
- Bounce: `key[1]` toggles every 2 cycles for 20 cycles, then settles low → no strobe during bounce. A single `write_add_subtract` pulse 7 cycles after the last toggle.
- Auto-repeat: hold `key[2]` 60 cycles after its first strobe at cycle T → `read_add_subtract` at T, T+20, T+28, T+36, T+44, T+52. None after release is debounced.
- Simultaneous: `key[1]` and `key[2]` fall in the same cycle → both strobes in the same cycle, every repeat aligned.
- Reset mid-repeat: assert `reset_n`=0 for 1 cycle at T+24 while `key[1]` is held → no strobe at T+28. FSM returns to IDLE; a new press strobe follows 7 cycles after reset release.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg
// Shared constants and types for the pulse_generator front-panel controller.
//   MODE_W               width of mode_sel
//   NUM_KEYS             number of front-panel buttons
//   KEY_MODE/KEY_WR/KEY_RD  bit index of each button within key[]
//   rep_state_t          state of a step-key auto-repeat FSM
//   max3()               largest of three integers, used to size counters
package pulse_gen_pkg;

  localparam int MODE_W   = 3;
  localparam int NUM_KEYS = 3;

  localparam int KEY_MODE = 0;
  localparam int KEY_WR   = 1;
  localparam int KEY_RD   = 2;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pulse_gen_ctrl_if.sv
// pulse_gen_ctrl_if
// Bundles the front-panel keys and the control outputs fed to pulse_generator.
//   key                 raw active-low buttons: [0] mode, [1] write step, [2] read step
//   mode_sel            registered mode select
//   write_add_subtract  one-cycle write-side step strobe
//   read_add_subtract   one-cycle read-side step strobe
//   key_held            debounced pressed level, 1 = pressed
// Modports: master drives the keys and observes the outputs (board / bench),
// slave is the controller itself.
interface pulse_gen_ctrl_if;
  import pulse_gen_pkg::*;

  logic [NUM_KEYS-1:0] key;
  logic [MODE_W-1:0]   mode_sel;
  logic                write_add_subtract;
  logic                read_add_subtract;
  logic [NUM_KEYS-1:0] key_held;

  modport master (
    output key,
    input  mode_sel,
    input  write_add_subtract,
    input  read_add_subtract,
    input  key_held
  );

  modport slave (
    input  key,
    output mode_sel,
    output write_add_subtract,
    output read_add_subtract,
    output key_held
  );

endinterface

// File: rtl/key_debounce.sv
// key_debounce
// Synchronises one raw active-low button and accepts a level change only after
// it has been seen for DEBOUNCE_CYCLES consecutive cycles.
//   clk      system clock
//   reset_n  synchronous active-low reset
//   key_n    raw asynchronous button, 0 = pressed
//   held     debounced level, 1 = pressed
//   press    one-cycle pulse when the debounced level goes released -> pressed
//   rel      one-cycle pulse when the debounced level goes pressed -> released
//            ("release" itself is a reserved word)
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic held,
  output logic press,
  output logic rel
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             key_p0;
  logic             key_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchroniser
      key_p0 <= key_n;
      key_p1 <= key_p0;
      // stage p1 -> stable: counter runs only while the synced level disagrees
      press  <= 1'b0;
      rel    <= 1'b0;
      if (key_p1 == stable) begin
        cnt <= '0;
      end else if (cnt_nxt == CNT_W'(DEBOUNCE_CYCLES)) begin
        stable <= key_p1;
        cnt    <= '0;
        press  <= ~key_p1;
        rel    <= key_p1;
      end else begin
        cnt <= cnt_nxt;
      end
    end
  end

  assign held = ~stable;

endmodule

// File: rtl/pulse_gen_ctrl.sv
// pulse_gen_ctrl
// Front-panel controller for pulse_generator. Debounces the three buttons,
// cycles mode_sel on each mode press and produces single-cycle step strobes
// with hold-to-repeat for the write and read step keys.
//   clk      system clock (50 MHz)
//   reset_n  synchronous active-low reset
//   bus      pulse_gen_ctrl_if.slave: key in; mode_sel, write_add_subtract,
//            read_add_subtract, key_held out (all straight from flops)
module pulse_gen_ctrl
  import pulse_gen_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = 1_000_000,
  parameter int                REPEAT_DELAY    = 25_000_000,
  parameter int                REPEAT_PERIOD   = 5_000_000,
  parameter int                NUM_MODES       = 8,
  parameter logic [MODE_W-1:0] MODE_RESET      = 3'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  pulse_gen_ctrl_if.slave  bus
);

  localparam int REP_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [NUM_KEYS-1:0] held_db;
  logic [NUM_KEYS-1:0] press_db;
  logic [NUM_KEYS-1:0] rel_db;

  logic [MODE_W-1:0]   mode_sel_r;
  logic [NUM_KEYS-1:0] key_held_r;
  logic [1:0]          strobe_r;

  // The mode key has no use for its release event.
  logic unused_rel_mode;
  assign unused_rel_mode = rel_db[KEY_MODE];

  // stage: raw pins -> debounced levels and edge events
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .key_n   (bus.key[i]),
      .held    (held_db[i]),
      .press   (press_db[i]),
      .rel     (rel_db[i])
    );
  end

  // stage: events -> registered mode select and held levels
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_sel_r <= MODE_RESET;
      key_held_r <= '0;
    end else begin
      key_held_r <= held_db;
      if (press_db[KEY_MODE]) begin
        if (mode_sel_r == MODE_W'(NUM_MODES - 1))
          mode_sel_r <= '0;
        else
          mode_sel_r <= mode_sel_r + 1'b1;
      end
    end
  end

  // stage: events -> step strobes; one auto-repeat FSM per step key
  for (genvar j = 0; j < 2; j++) begin : g_rep
    localparam int K = KEY_WR + j;

    rep_state_t       state;
    logic [REP_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state       <= IDLE;
        cnt         <= '0;
        strobe_r[j] <= 1'b0;
      end else begin
        strobe_r[j] <= 1'b0;
        case (state)
          IDLE: begin
            if (press_db[K]) begin
              strobe_r[j] <= 1'b1;
              cnt         <= REP_W'(REPEAT_DELAY);
              state       <= DELAY;
            end
          end
          DELAY, REPEAT: begin
            // A release wins over a coincident expiry: no strobe on the way out.
            if (rel_db[K]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt <= REP_W'(1)) begin
              strobe_r[j] <= 1'b1;
              cnt         <= REP_W'(REPEAT_PERIOD);
              state       <= REPEAT;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.mode_sel           = mode_sel_r;
  assign bus.key_held           = key_held_r;
  assign bus.write_add_subtract = strobe_r[0];
  assign bus.read_add_subtract  = strobe_r[1];

endmodule

// File: tb/tb_pulse_gen_ctrl.sv
// tb_pulse_gen_ctrl
// Directed bench for pulse_gen_ctrl with small timing parameters:
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, NUM_MODES=5, MODE_RESET=0.
// Press-to-output latency is 7 edges counted from the first edge that samples
// the new raw key level.
module tb_pulse_gen_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   cyc;

  pulse_gen_ctrl_if bus ();

  pulse_gen_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .NUM_MODES       (5),
    .MODE_RESET      (3'd0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] key;
    int         cycles;
    logic [2:0] mode;
    logic [2:0] held;
  } vec_t;

  vec_t vecs [16];

  // Advance one rising edge; inputs set after this return are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Offsets (from the first strobe) at which a held step key strobes.
  function automatic int is_rep(input int k);
    return (k == 0 || (k >= 20 && (k - 20) % 8 == 0)) ? 1 : 0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;

    // Mode key vectors: applied key level, edges to advance, expected mode/held.
    vecs[0]  = '{3'b110,   6, 3'd0, 3'b000};
    vecs[1]  = '{3'b110,   1, 3'd1, 3'b001};
    vecs[2]  = '{3'b110, 100, 3'd1, 3'b001};
    vecs[3]  = '{3'b111,   6, 3'd1, 3'b001};
    vecs[4]  = '{3'b111,   1, 3'd1, 3'b000};
    vecs[5]  = '{3'b110,   7, 3'd2, 3'b001};
    vecs[6]  = '{3'b111,   7, 3'd2, 3'b000};
    vecs[7]  = '{3'b110,   7, 3'd3, 3'b001};
    vecs[8]  = '{3'b111,   7, 3'd3, 3'b000};
    vecs[9]  = '{3'b110,   7, 3'd4, 3'b001};
    vecs[10] = '{3'b111,   7, 3'd4, 3'b000};
    vecs[11] = '{3'b110,   6, 3'd4, 3'b000};
    vecs[12] = '{3'b110,   1, 3'd0, 3'b001};
    vecs[13] = '{3'b111,   7, 3'd0, 3'b000};
    vecs[14] = '{3'b110,   3, 3'd0, 3'b000};
    vecs[15] = '{3'b111,  12, 3'd0, 3'b000};

    // Reset with all keys pressed.
    reset_n = 1'b0;
    bus.key = 3'b000;
    repeat (3) tick();
    chk("rst_mode", int'(bus.mode_sel), 0);
    chk("rst_wr", int'(bus.write_add_subtract), 0);
    chk("rst_rd", int'(bus.read_add_subtract), 0);
    chk("rst_held", int'(bus.key_held), 0);

    // Keys held through reset register as presses at edge 7 after release.
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("rel_wr", int'(bus.write_add_subtract), (e == 7) ? 1 : 0);
      chk("rel_rd", int'(bus.read_add_subtract), (e == 7) ? 1 : 0);
      if (e == 6) chk("rel_held_pre", int'(bus.key_held), 0);
      if (e == 7) begin
        chk("rel_held", int'(bus.key_held), 7);
        chk("rel_mode", int'(bus.mode_sel), 1);
      end
    end
    bus.key = 3'b111;
    for (int e = 0; e < 30; e++) begin
      tick();
      chk("rel_idle_wr", int'(bus.write_add_subtract), 0);
      chk("rel_idle_rd", int'(bus.read_add_subtract), 0);
    end
    chk("rel_idle_held", int'(bus.key_held), 0);

    // Fresh reset with keys released to restart the mode count at 0.
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    chk("rst2_mode", int'(bus.mode_sel), 0);

    // Mode wrap, hold, latency and glitch rejection.
    for (int v = 0; v < 16; v++) begin
      bus.key = vecs[v].key;
      repeat (vecs[v].cycles) tick();
      chk($sformatf("mode_v%0d", v), int'(bus.mode_sel), int'(vecs[v].mode));
      chk($sformatf("held_v%0d", v), int'(bus.key_held), int'(vecs[v].held));
      chk($sformatf("wr_v%0d", v), int'(bus.write_add_subtract), 0);
      chk($sformatf("rd_v%0d", v), int'(bus.read_add_subtract), 0);
    end

    // Bounce on the write key, then a clean settle low.
    for (int i = 0; i < 10; i++) begin
      bus.key[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        tick();
        chk("bounce_wr", int'(bus.write_add_subtract), 0);
      end
    end
    bus.key[1] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("settle_wr", int'(bus.write_add_subtract), (e == 7) ? 1 : 0);
    end
    bus.key[1] = 1'b1;
    for (int e = 0; e < 25; e++) begin
      tick();
      chk("settle_idle_wr", int'(bus.write_add_subtract), 0);
    end

    // Auto-repeat on the read key; release reaches the FSM exactly at an expiry.
    bus.key[2] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("rep_pre_rd", int'(bus.read_add_subtract), 0);
    end
    tick();
    for (int k = 0; k <= 80; k++) begin
      if (k > 0) tick();
      chk("rep_rd", int'(bus.read_add_subtract), (k <= 53) ? is_rep(k) : 0);
      chk("rep_wr", int'(bus.write_add_subtract), 0);
      if (k == 53) bus.key[2] = 1'b1;
    end

    // Both step keys pressed in the same cycle stay aligned.
    bus.key = 3'b001;
    repeat (6) tick();
    chk("sim_pre_wr", int'(bus.write_add_subtract), 0);
    tick();
    for (int k = 0; k <= 80; k++) begin
      if (k > 0) tick();
      chk("sim_wr", int'(bus.write_add_subtract), (k <= 53) ? is_rep(k) : 0);
      chk("sim_rd", int'(bus.read_add_subtract), (k <= 53) ? is_rep(k) : 0);
      if (k == 53) bus.key = 3'b111;
    end

    // Reset pulse mid-repeat while the write key stays held.
    bus.key[1] = 1'b0;
    repeat (6) tick();
    tick();
    chk("mid_wr_first", int'(bus.write_add_subtract), 1);
    for (int k = 1; k <= 23; k++) begin
      tick();
      chk("mid_wr", int'(bus.write_add_subtract), is_rep(k));
    end
    reset_n = 1'b0;
    tick();
    chk("mid_rst_wr", int'(bus.write_add_subtract), 0);
    chk("mid_rst_held", int'(bus.key_held), 0);
    chk("mid_rst_mode", int'(bus.mode_sel), 0);
    reset_n = 1'b1;
    for (int k = 25; k <= 51; k++) begin
      tick();
      chk("mid_post_wr", int'(bus.write_add_subtract), (k == 31 || k == 51) ? 1 : 0);
    end
    bus.key = 3'b111;
    for (int e = 0; e < 25; e++) begin
      tick();
      chk("mid_idle_wr", int'(bus.write_add_subtract), 0);
    end
    chk("end_held", int'(bus.key_held), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
